// File: rtl/pipe_hazard_ctrl.sv
// Purpose : Y86-64 five-stage pipeline control: hazard stall/bubble generation,
//           SET_CC gating, condition-code register, RUN/DRAIN/HALTED FSM and
//           a saturating stall-cycle counter.
// Latency : stall/bubble/SET_CC are combinational; cc, pipe_state and
//           stall_count update on the rising edge (1 cycle).
// Backpressure: none accepted; this block is the source of pipeline backpressure
//           (F_stall/D_stall/W_stall).
//
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   D_icode, d_srcA/B   - decode-stage icode and source register IDs
//   E_icode, E_dstM,    - execute-stage icode, load destination and
//   e_Cnd, e_flags        branch/cmov condition, freshly computed {ZF,SF,OF}
//   M_icode, m_stat     - memory-stage icode and status
//   W_stat              - writeback-stage status
//   F_stall..W_stall    - per-stage stall/bubble controls
//   SET_CC, cc          - flag-update enable and registered {ZF,SF,OF}
//   pipe_state          - 0=RUN, 1=DRAIN, 2=HALTED
//   stall_count         - saturating count of F_stall cycles spent in RUN
module pipe_hazard_ctrl #(
  parameter int         CNT_W = 16,
  parameter logic [3:0] RNONE = 4'd15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  input  logic [2:0]       e_flags,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             SET_CC,
  output logic [2:0]       cc,
  output logic [1:0]       pipe_state,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_POPQ   = 4'd11;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic loaduse;
  logic ret_haz;
  logic mispredict;
  logic m_bad;
  logic w_bad;

  // A load in E whose destination feeds decode must hold D for one cycle.
  assign loaduse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                   (E_dstM != RNONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));

  assign ret_haz    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign mispredict = (E_icode == I_JXX) && !e_Cnd;
  assign m_bad      = (m_stat != 3'd0);
  assign w_bad      = (W_stat != 3'd0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next-state logic: a bad status reaching W always wins over one in M.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (w_bad)      state_d = ST_HALTED;
        else if (m_bad) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_bad) state_d = ST_HALTED;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    SET_CC   = 1'b0;
    if (!reset) begin
      if (state_q == ST_HALTED) begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
      end else begin
        F_stall  = loaduse | ret_haz;
        D_stall  = loaduse;
        // When a load/use stall holds D, the ret bubble must not clobber it.
        D_bubble = mispredict | (ret_haz & !loaduse);
        E_bubble = mispredict | loaduse;
        M_bubble = m_bad | w_bad;
        W_stall  = w_bad;
        // Flags may not change once an exception is on its way out.
        SET_CC   = (state_q == ST_RUN) && (E_icode == I_OPQ) && !m_bad && !w_bad;
      end
    end
  end

  assign pipe_state = state_q;

  // Condition codes: written one cycle after the OPQ sits in E.
  always_ff @(posedge clk) begin
    if (reset)       cc <= 3'b000;
    else if (SET_CC) cc <= e_flags;
  end

  // Saturating stall counter; only RUN-state stalls are counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (F_stall && (state_q == ST_RUN) && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose : self-checking bench for pipe_hazard_ctrl (two instances: 16-bit and
//           2-bit stall counters sharing the same stimulus).
// Latency : expectations are queued per cycle and compared at the falling edge.
// Backpressure: none; the monitor pops one expectation per cycle.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic       e_Cnd;
  logic [2:0] m_stat, W_stat, e_flags;

  logic        f0, d0, db0, eb0, mb0, w0, s0;
  logic [2:0]  cc0;
  logic [1:0]  st0;
  logic [15:0] cnt0;
  logic        f1, d1, db1, eb1, mb1, w1, s1;
  logic [2:0]  cc1;
  logic [1:0]  st1;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .e_flags(e_flags),
    .F_stall(f0), .D_stall(d0), .D_bubble(db0), .E_bubble(eb0), .M_bubble(mb0),
    .W_stall(w0), .SET_CC(s0), .cc(cc0), .pipe_state(st0), .stall_count(cnt0));

  pipe_hazard_ctrl #(.CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .e_flags(e_flags),
    .F_stall(f1), .D_stall(d1), .D_bubble(db1), .E_bubble(eb1), .M_bubble(mb1),
    .W_stall(w1), .SET_CC(s1), .cc(cc1), .pipe_state(st1), .stall_count(cnt1));

  // ctl bit order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, SET_CC}
  typedef struct {
    logic [6:0]  ctl;
    logic [2:0]  cc;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state, in terms of the architectural story rather than an encoding.
  bit        halted, draining;
  logic [2:0] m_cc;
  int        m_cnt, m_cnt2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_ctl();
    bit lu, rt, mp, bm, bw;
    bit fs, ds, dbb, ebb, mbb, ws, sc;
    if (reset) return 7'b0;
    if (halted) return 7'b1101110;
    lu = (E_icode == 5 || E_icode == 11) && E_dstM != 15 && (E_dstM == d_srcA || E_dstM == d_srcB);
    rt = (D_icode == 9) || (E_icode == 9) || (M_icode == 9);
    mp = (E_icode == 7) && !e_Cnd;
    bm = m_stat != 0;
    bw = W_stat != 0;
    fs  = lu || rt;
    ds  = lu;
    dbb = mp || (rt && !lu);
    ebb = mp || lu;
    mbb = bm || bw;
    ws  = bw;
    sc  = !draining && E_icode == 6 && !bm && !bw;
    return {fs, ds, dbb, ebb, mbb, ws, sc};
  endfunction

  task automatic model_update(input logic [6:0] c);
    if (reset) begin
      halted = 0; draining = 0; m_cc = 3'b000; m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (c[0]) m_cc = e_flags;
      if (c[6] && !halted && !draining) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (!halted) begin
        if (W_stat != 0) begin halted = 1; draining = 0; end
        else if (m_stat != 0) draining = 1;
      end
    end
  endtask

  // One clock of stimulus: queue the expectation for the current inputs, then advance.
  task automatic cycle();
    exp_t e;
    e.ctl  = model_ctl();
    e.cc   = m_cc;
    e.st   = halted ? 2'd2 : (draining ? 2'd1 : 2'd0);
    e.cnt  = 16'(m_cnt);
    e.cnt2 = 2'(m_cnt2);
    sb.push_back(e);
    @(posedge clk);
    model_update(e.ctl);
    #1;
  endtask

  task automatic set_idle();
    reset = 0; D_icode = 4'd1; d_srcA = 4'd15; d_srcB = 4'd15;
    E_icode = 4'd1; E_dstM = 4'd15; e_Cnd = 1'b1; M_icode = 4'd1;
    m_stat = 3'd0; W_stat = 3'd0; e_flags = 3'd0;
  endtask

  function automatic logic [3:0] pick_icode();
    logic [3:0] tbl [8];
    tbl = '{4'd1, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11, 4'd2, 4'd0};
    return tbl[$urandom_range(0, 7)];
  endfunction

  function automatic logic [3:0] pick_reg();
    int r;
    r = $urandom_range(0, 5);
    return (r == 5) ? 4'd15 : 4'(r);
  endfunction

  function automatic logic [2:0] pick_stat();
    return ($urandom_range(0, 39) == 0) ? 3'($urandom_range(1, 3)) : 3'd0;
  endfunction

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("F_stall",  32'(f0),  32'(e.ctl[6]));
        chk("D_stall",  32'(d0),  32'(e.ctl[5]));
        chk("D_bubble", 32'(db0), 32'(e.ctl[4]));
        chk("E_bubble", 32'(eb0), 32'(e.ctl[3]));
        chk("M_bubble", 32'(mb0), 32'(e.ctl[2]));
        chk("W_stall",  32'(w0),  32'(e.ctl[1]));
        chk("SET_CC",   32'(s0),  32'(e.ctl[0]));
        chk("cc",          32'(cc0),  32'(e.cc));
        chk("pipe_state",  32'(st0),  32'(e.st));
        chk("stall_count", 32'(cnt0), 32'(e.cnt));
        chk("ctl_w2",  32'({f1, d1, db1, eb1, mb1, w1, s1}), 32'(e.ctl));
        chk("cc_w2",   32'({cc1, st1}), 32'({e.cc, e.st}));
        chk("stall_count_w2", 32'(cnt1), 32'(e.cnt2));
      end
    end
  end

  initial begin
    int budget;
    set_idle();
    reset = 1;
    @(posedge clk);
    model_update(7'b0);
    #1;
    cycle();                          // reset held: everything zero

    // load/use on rA
    set_idle(); E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3; cycle();
    set_idle(); cycle();
    // load with RNONE destination is not a hazard
    set_idle(); E_icode = 4'd5; E_dstM = 4'd15; d_srcA = 4'd15; cycle();
    // ret walking D, E, M
    set_idle(); D_icode = 4'd9; cycle();
    set_idle(); E_icode = 4'd9; cycle();
    set_idle(); M_icode = 4'd9; cycle();
    set_idle(); cycle();
    // ret together with load/use
    set_idle(); D_icode = 4'd9; E_icode = 4'd11; E_dstM = 4'd2; d_srcB = 4'd2; cycle();
    // mispredicted jump
    set_idle(); E_icode = 4'd7; e_Cnd = 1'b0; cycle();
    set_idle(); E_icode = 4'd7; e_Cnd = 1'b1; cycle();
    // flag update, then blocked by a bad m_stat, then halt via W
    set_idle(); E_icode = 4'd6; e_flags = 3'b100; cycle();
    set_idle(); E_icode = 4'd6; e_flags = 3'b011; m_stat = 3'd2; cycle();
    set_idle(); E_icode = 4'd6; e_flags = 3'b010; cycle();
    set_idle(); W_stat = 3'd2; cycle();
    set_idle(); E_icode = 4'd6; e_flags = 3'b111; cycle();
    set_idle(); cycle();
    set_idle(); reset = 1; cycle();
    // HLT path: RUN, DRAIN, HALTED, sticky, reset
    set_idle(); E_icode = 4'd6; e_flags = 3'b001; cycle();
    set_idle(); m_stat = 3'd1; cycle();
    set_idle(); W_stat = 3'd1; cycle();
    for (int i = 0; i < 3; i++) begin set_idle(); cycle(); end
    set_idle(); reset = 1; cycle();
    set_idle(); cycle();
    // sustained load/use: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      set_idle(); E_icode = 4'd11; E_dstM = 4'd2; d_srcB = 4'd2; cycle();
    end
    set_idle(); cycle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 24) == 0);
      D_icode = pick_icode();
      d_srcA  = pick_reg();
      d_srcB  = pick_reg();
      E_icode = pick_icode();
      E_dstM  = pick_reg();
      e_Cnd   = 1'($urandom_range(0, 1));
      M_icode = pick_icode();
      m_stat  = pick_stat();
      W_stat  = pick_stat();
      e_flags = 3'($urandom_range(0, 7));
      cycle();
    end

    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
